// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - shared types and codes for the SPI transfer scheduler
package spi_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      CAPTURE,
      GAP
   } state_t;

   localparam logic [1:0] CS_IDLE = 2'b00;

   localparam logic [1:0] RW_NONE = 2'b00;
   localparam logic [1:0] RW_WR   = 2'b01;
   localparam logic [1:0] RW_RD   = 2'b10;
   localparam logic [1:0] RW_RW   = 2'b11;

   localparam logic [1:0] MODE0 = 2'd0;
   localparam logic [1:0] MODE1 = 2'd1;
   localparam logic [1:0] MODE2 = 2'd2;
   localparam logic [1:0] MODE3 = 2'd3;

   // Index of the set bit in a 3-bit one-hot vector (0 when empty).
   function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
      logic [1:0] idx;
      idx = 2'd0;
      if (oh[1]) idx = 2'd1;
      if (oh[2]) idx = 2'd2;
      return idx;
   endfunction

endpackage

// File: rtl/spi_xfer_scheduler_if.sv
// rtl/spi_xfer_scheduler_if.sv - requester and SPI-master side signals of the scheduler
interface spi_xfer_scheduler_if #(
   parameter int unsigned DATA_W = 8
);
   logic [2:0]          req;
   logic [5:0]          req_rw;
   logic [5:0]          req_mode;
   logic [3*DATA_W-1:0] req_wdata;
   logic [2:0]          grant;
   logic [2:0]          done;
   logic [DATA_W-1:0]   rdata;
   logic                busy;
   logic [1:0]          spi_cs;
   logic [1:0]          spi_mode;
   logic [1:0]          spi_rw;
   logic [DATA_W-1:0]   spi_tx_data;
   logic [DATA_W-1:0]   spi_rx_data;

   // Scheduler side
   modport slave (
      input  req, req_rw, req_mode, req_wdata, spi_rx_data,
      output grant, done, rdata, busy, spi_cs, spi_mode, spi_rw, spi_tx_data
   );

   // Requesters plus SPI master side
   modport master (
      output req, req_rw, req_mode, req_wdata, spi_rx_data,
      input  grant, done, rdata, busy, spi_cs, spi_mode, spi_rw, spi_tx_data
   );
endinterface

// File: rtl/spi_rr_arbiter.sv
// rtl/spi_rr_arbiter.sv - 3-way round-robin arbiter, search starts after the pointer
module spi_rr_arbiter (
   input  logic [2:0] req_i,
   input  logic [1:0] ptr_i,
   output logic [2:0] winner_o,
   output logic       valid_o
);

   // Walk the search order from farthest to nearest so the nearest requester after the pointer wins.
   always_comb begin
      logic [1:0] idx;
      idx      = 2'd0;
      winner_o = 3'b000;
      valid_o  = |req_i;
      for (int k = 3; k >= 1; k--) begin
         idx = 2'((int'(ptr_i) + k) % 3);
         if (req_i[idx]) begin
            winner_o = 3'b001 << idx;
         end
      end
   end

endmodule

// File: rtl/spi_xfer_scheduler.sv
// rtl/spi_xfer_scheduler.sv - shares one byte-wide SPI master between three requesters
module spi_xfer_scheduler
   import spi_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned XFER_CYCLES = 8,
   parameter int unsigned GAP_CYCLES  = 2
) (
   input logic                  sclk,
   input logic                  reset,
   spi_xfer_scheduler_if.slave  bus
);

   localparam int unsigned CNT_MAX = (XFER_CYCLES > GAP_CYCLES) ? XFER_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] XFER_LAST = CNT_W'(XFER_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          ptr_q, ptr_d;
   logic [1:0]          owner_q, owner_d;
   logic [2:0]          grant_q, grant_d;
   logic [2:0]          done_q, done_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          spi_cs_q, spi_cs_d;
   logic [1:0]          spi_mode_q, spi_mode_d;
   logic [1:0]          spi_rw_q, spi_rw_d;
   logic [DATA_W-1:0]   spi_tx_q, spi_tx_d;

   logic [2:0]          arb_winner;
   logic                arb_valid;
   logic [1:0]          win_idx;

   spi_rr_arbiter u_arb (
      .req_i    (bus.req),
      .ptr_i    (ptr_q),
      .winner_o (arb_winner),
      .valid_o  (arb_valid)
   );

   assign win_idx = onehot_to_idx(arb_winner);

   // Next state, payload latch on grant, and rdata capture on entry to CAPTURE so it is valid with done.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      grant_d    = grant_q;
      rdata_d    = rdata_q;
      spi_mode_d = spi_mode_q;
      spi_rw_d   = spi_rw_q;
      spi_tx_d   = spi_tx_q;

      unique case (state_q)
         IDLE: begin
            if (arb_valid) begin
               state_d    = SETUP;
               owner_d    = win_idx;
               grant_d    = arb_winner;
               spi_rw_d   = bus.req_rw[{win_idx, 1'b0} +: 2];
               spi_mode_d = bus.req_mode[{win_idx, 1'b0} +: 2];
               spi_tx_d   = bus.req_wdata[win_idx * DATA_W +: DATA_W];
            end
         end
         SETUP: begin
            ptr_d   = owner_q;
            state_d = (spi_rw_q == RW_NONE) ? CAPTURE : SHIFT;
         end
         SHIFT: begin
            if (cnt_q == XFER_LAST) begin
               cnt_d   = '0;
               state_d = CAPTURE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         CAPTURE: begin
            state_d = GAP;
            grant_d = 3'b000;
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            grant_d = 3'b000;
         end
      endcase

      if ((state_d == CAPTURE) && (state_q != CAPTURE) && spi_rw_q[1]) begin
         rdata_d = bus.spi_rx_data;
      end
   end

   // CS and done are decoded from the next state so they come straight out of flops.
   always_comb begin
      spi_cs_d = CS_IDLE;
      done_d   = 3'b000;
      if (state_d == SHIFT)   spi_cs_d = owner_d + 2'd1;
      if (state_d == CAPTURE) done_d   = grant_d;
   end

   // State and output registers; reset drops CS immediately and abandons any byte in flight.
   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ptr_q      <= 2'd2;
         owner_q    <= 2'd0;
         grant_q    <= 3'b000;
         done_q     <= 3'b000;
         rdata_q    <= '0;
         spi_cs_q   <= CS_IDLE;
         spi_mode_q <= 2'b00;
         spi_rw_q   <= RW_NONE;
         spi_tx_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         grant_q    <= grant_d;
         done_q     <= done_d;
         rdata_q    <= rdata_d;
         spi_cs_q   <= spi_cs_d;
         spi_mode_q <= spi_mode_d;
         spi_rw_q   <= spi_rw_d;
         spi_tx_q   <= spi_tx_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.done        = done_q;
   assign bus.rdata       = rdata_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.spi_cs      = spi_cs_q;
   assign bus.spi_mode    = spi_mode_q;
   assign bus.spi_rw      = spi_rw_q;
   assign bus.spi_tx_data = spi_tx_q;

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// tb/tb_spi_xfer_scheduler.sv - self-checking bench for spi_xfer_scheduler
module tb_spi_xfer_scheduler;
   import spi_ctrl_pkg::*;

   localparam int DATA_W = 8;
   localparam int XFER   = 8;
   localparam int GAPC   = 2;

   logic sclk  = 1'b0;
   logic reset = 1'b1;

   always #5 sclk = ~sclk;

   spi_xfer_scheduler_if #(.DATA_W(DATA_W)) bus ();

   spi_xfer_scheduler #(
      .DATA_W      (DATA_W),
      .XFER_CYCLES (XFER),
      .GAP_CYCLES  (GAPC)
   ) dut (
      .sclk  (sclk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [2:0]  req;
      logic [5:0]  rw;
      logic [5:0]  mode;
      logic [23:0] wdata;
      logic [7:0]  rx;
      int          win;
      logic [7:0]  rdata;
   } vec_t;

   vec_t       vecs [7];
   int         checks   = 0;
   int         failures = 0;
   string      cur_tag  = "reset";
   int         model_last;
   logic [7:0] model_rdata;
   logic [1:0] prev_mode = 2'b00;
   logic [1:0] prev_cs   = 2'b00;
   logic       prev_rst  = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL [%s] %s: got %0h expected %0h", cur_tag, name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge sclk);
      if (!reset && !prev_rst) begin
         if (bus.spi_mode != prev_mode) begin
            chk("mode_change_while_cs_idle",
                32'((prev_cs == CS_IDLE) && (bus.spi_cs == CS_IDLE)), 32'd1);
         end
         chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
         chk("done_onehot0", 32'($onehot0(bus.done)), 32'd1);
      end
      prev_mode = bus.spi_mode;
      prev_cs   = bus.spi_cs;
      prev_rst  = reset;
   endtask

   task automatic drive(input logic [2:0] r, input logic [5:0] rw, input logic [5:0] m,
                        input logic [23:0] wd, input logic [7:0] rx);
      bus.req         = r;
      bus.req_rw      = rw;
      bus.req_mode    = m;
      bus.req_wdata   = wd;
      bus.spi_rx_data = rx;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.busy && n < 100);
      if (bus.busy) chk("wait_idle_timeout", 32'(bus.busy), 32'd0);
   endtask

   function automatic int rr_pick(input logic [2:0] r, input int last);
      for (int k = 1; k <= 3; k++) begin
         if (r[(last + k) % 3]) return (last + k) % 3;
      end
      return 0;
   endfunction

   // One byte from grant to end of gap, checked against the expected winner and rdata.
   task automatic run_xfer(input logic [2:0] r, input logic [5:0] rw, input logic [5:0] m,
                           input logic [23:0] wd, input logic [7:0] rx,
                           input int win, input logic [7:0] exp_rdata);
      logic [1:0] w_rw;
      logic [1:0] w_mode;
      logic [7:0] w_wd;
      logic [2:0] w_oh;
      int         len;
      wait_idle();
      drive(r, rw, m, wd, rx);
      w_rw   = rw[2*win +: 2];
      w_mode = m[2*win +: 2];
      w_wd   = wd[8*win +: 8];
      w_oh   = 3'(1 << win);
      len    = (w_rw == RW_NONE) ? 0 : XFER;
      tick();
      chk("setup_grant", 32'(bus.grant), 32'(w_oh));
      chk("setup_cs", 32'(bus.spi_cs), 32'(CS_IDLE));
      chk("setup_rw", 32'(bus.spi_rw), 32'(w_rw));
      chk("setup_mode", 32'(bus.spi_mode), 32'(w_mode));
      chk("setup_tx", 32'(bus.spi_tx_data), 32'(w_wd));
      chk("setup_busy", 32'(bus.busy), 32'd1);
      chk("setup_done", 32'(bus.done), 32'd0);
      drive(3'($urandom), 6'($urandom), 6'($urandom), 24'($urandom), rx);
      for (int k = 0; k < len; k++) begin
         tick();
         chk("shift_cs", 32'(bus.spi_cs), 32'(win + 1));
         chk("shift_tx", 32'(bus.spi_tx_data), 32'(w_wd));
         chk("shift_mode", 32'(bus.spi_mode), 32'(w_mode));
         chk("shift_rw", 32'(bus.spi_rw), 32'(w_rw));
         chk("shift_done", 32'(bus.done), 32'd0);
         chk("shift_grant", 32'(bus.grant), 32'(w_oh));
      end
      tick();
      chk("capture_done", 32'(bus.done), 32'(w_oh));
      chk("capture_cs", 32'(bus.spi_cs), 32'(CS_IDLE));
      chk("capture_rdata", 32'(bus.rdata), 32'(exp_rdata));
      chk("capture_grant", 32'(bus.grant), 32'(w_oh));
      for (int k = 0; k < GAPC; k++) begin
         tick();
         chk("gap_grant", 32'(bus.grant), 32'd0);
         chk("gap_cs", 32'(bus.spi_cs), 32'(CS_IDLE));
         chk("gap_done", 32'(bus.done), 32'd0);
         chk("gap_busy", 32'(bus.busy), 32'd1);
      end
   endtask

   initial begin
      logic [2:0]  r;
      logic [5:0]  rw;
      logic [5:0]  m;
      logic [23:0] wd;
      logic [7:0]  rx;
      int          win;
      logic [2:0]  rise_val [4];
      int          rise_cyc [4];
      int          rises, cyc, idle_run, min_idle, max_idle, n;
      logic [2:0]  prev_g;
      logic        saw_active, saw_done;

      vecs[0] = '{3'b001, 6'b00_00_01, 6'b00_00_00, 24'h0000A5, 8'hFF, 0, 8'h00};
      vecs[1] = '{3'b100, 6'b10_00_00, 6'b01_00_00, 24'h110000, 8'h3C, 2, 8'h3C};
      vecs[2] = '{3'b010, 6'b00_00_00, 6'b00_10_00, 24'h002200, 8'h99, 1, 8'h3C};
      vecs[3] = '{3'b111, 6'b11_11_11, 6'b11_10_01, 24'h332211, 8'h5A, 2, 8'h5A};
      vecs[4] = '{3'b011, 6'b00_01_11, 6'b00_11_00, 24'h007766, 8'h42, 0, 8'h42};
      vecs[5] = '{3'b011, 6'b00_11_10, 6'b00_11_00, 24'h008877, 8'h81, 1, 8'h81};
      vecs[6] = '{3'b101, 6'b01_00_10, 6'b10_00_00, 24'h990055, 8'hE7, 2, 8'h81};

      drive(3'b000, 6'd0, 6'd0, 24'd0, 8'd0);
      tick();
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_rdata", 32'(bus.rdata), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_cs", 32'(bus.spi_cs), 32'd0);
      chk("rst_mode", 32'(bus.spi_mode), 32'd0);
      chk("rst_rw", 32'(bus.spi_rw), 32'd0);
      chk("rst_tx", 32'(bus.spi_tx_data), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 7; i++) begin
         cur_tag = $sformatf("vec%0d", i);
         run_xfer(vecs[i].req, vecs[i].rw, vecs[i].mode, vecs[i].wdata, vecs[i].rx,
                  vecs[i].win, vecs[i].rdata);
      end
      model_last  = 2;
      model_rdata = 8'h81;

      for (int t = 0; t < 40; t++) begin
         cur_tag = $sformatf("rand%0d", t);
         r   = 3'($urandom_range(1, 7));
         rw  = 6'($urandom);
         m   = 6'($urandom);
         wd  = 24'($urandom);
         rx  = 8'($urandom);
         win = rr_pick(r, model_last);
         model_last = win;
         if (rw[2*win + 1]) model_rdata = rx;
         run_xfer(r, rw, m, wd, rx, win, model_rdata);
      end

      cur_tag = "rr_hold";
      wait_idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(3'b111, 6'b11_11_11, 6'b00_00_00, 24'h030201, 8'h77);
      for (int i = 0; i < 4; i++) begin
         rise_val[i] = 3'b000;
         rise_cyc[i] = 0;
      end
      rises = 0; cyc = 0; idle_run = 0; min_idle = 1000; max_idle = 0;
      prev_g = 3'b000; saw_active = 1'b0;
      while (rises < 4 && cyc < 80) begin
         tick();
         cyc++;
         if (prev_g == 3'b000 && bus.grant != 3'b000) begin
            rise_val[rises] = bus.grant;
            rise_cyc[rises] = cyc;
            rises++;
         end
         prev_g = bus.grant;
         if (bus.spi_cs == CS_IDLE) begin
            idle_run++;
         end else begin
            if (saw_active && idle_run > 0) begin
               if (idle_run < min_idle) min_idle = idle_run;
               if (idle_run > max_idle) max_idle = idle_run;
            end
            saw_active = 1'b1;
            idle_run   = 0;
         end
      end
      chk("rr_rises", 32'(rises), 32'd4);
      chk("rr_grant0", 32'(rise_val[0]), 32'b001);
      chk("rr_grant1", 32'(rise_val[1]), 32'b010);
      chk("rr_grant2", 32'(rise_val[2]), 32'b100);
      chk("rr_grant3", 32'(rise_val[3]), 32'b001);
      for (int i = 0; i < 3; i++) begin
         chk("rr_period", 32'(rise_cyc[i+1] - rise_cyc[i]), 32'(XFER + GAPC + 3));
      end
      chk("rr_cs_idle_min", 32'(min_idle), 32'(GAPC + 3));
      chk("rr_cs_idle_max", 32'(max_idle), 32'(GAPC + 3));
      drive(3'b000, 6'd0, 6'd0, 24'd0, 8'd0);
      wait_idle();

      cur_tag = "reset_mid";
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(3'b001, 6'b00_00_01, 6'b00_00_00, 24'h0000C3, 8'h00);
      tick();
      chk("rm_grant", 32'(bus.grant), 32'b001);
      for (int k = 0; k < 4; k++) tick();
      chk("rm_cs_active", 32'(bus.spi_cs), 32'b01);
      reset = 1'b1;
      #1;
      chk("rm_cs_async", 32'(bus.spi_cs), 32'(CS_IDLE));
      chk("rm_grant_async", 32'(bus.grant), 32'd0);
      chk("rm_busy_async", 32'(bus.busy), 32'd0);
      saw_done = 1'b0;
      for (int k = 0; k < XFER; k++) begin
         tick();
         if (bus.done != 3'b000) saw_done = 1'b1;
      end
      reset = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
         if (bus.done != 3'b000) saw_done = 1'b1;
      end while (bus.grant == 3'b000 && n < 20);
      chk("rm_no_done", 32'(saw_done), 32'd0);
      chk("rm_regrant", 32'(bus.grant), 32'b001);
      chk("rm_regrant_latency", 32'(n), 32'd1);
      drive(3'b000, 6'd0, 6'd0, 24'd0, 8'd0);
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
